// File: rtl/syn_fetch_queue_if.sv
// Decode-side handshake of the fetch queue: head entry {pc, pc+1, inst} with valid/ready.
interface syn_fetch_queue_if #(
  parameter int ADDR_BIT = 10
) ();
  logic                out_valid;
  logic                out_ready;
  logic [ADDR_BIT-1:0] out_pc;
  logic [ADDR_BIT-1:0] out_pc_4;
  logic [31:0]         out_inst;

  modport master (output out_valid, output out_pc, output out_pc_4, output out_inst, input out_ready);
  modport slave  (input out_valid, input out_pc, input out_pc_4, input out_inst, output out_ready);
endinterface

// File: rtl/syn_fetch_queue.sv
// Instruction-fetch front end: owns fetch PC, buffers {pc, inst} in a DEPTH-entry queue for decode.
// Define FETCH_QUEUE_PERF_EN to add saturating perf_fetched / perf_flushed counters.
module syn_fetch_queue #(
  parameter int ADDR_BIT = 10,
  parameter int DEPTH    = 4,
  parameter int RESET_PC = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   halt,
  input  logic                   redirect,
  input  logic [ADDR_BIT-1:0]    redirect_pc,
  output logic [ADDR_BIT-1:0]    imem_addr,
  input  logic [31:0]            imem_inst,
  syn_fetch_queue_if.master      deq,
  output logic [$clog2(DEPTH):0] count
`ifdef FETCH_QUEUE_PERF_EN
  ,
  output logic [31:0]            perf_fetched,
  output logic [31:0]            perf_flushed
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [ADDR_BIT-1:0] fetch_pc_reg;
  logic [PTR_W-1:0]    rd_ptr_reg;
  logic [PTR_W-1:0]    wr_ptr_reg;
  logic [CNT_W-1:0]    count_reg;
  logic [CNT_W-1:0]    count_next;
  logic                push;
  logic                pop;

  logic [ADDR_BIT-1:0] pc_mem_reg   [DEPTH];
  logic [31:0]         inst_mem_reg [DEPTH];

  assign pop  = en & ~redirect & (count_reg != '0) & deq.out_ready;
  // A full queue still accepts a fetch when the head leaves in the same cycle.
  assign push = en & ~redirect & ~halt & ((count_reg < DEPTH_C) | pop);

  always_comb begin
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + CNT_W'(1);
    end else if (pop && !push) begin
      count_next = count_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_reg <= ADDR_BIT'(RESET_PC);
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
    end else if (en) begin
      if (redirect) begin
        fetch_pc_reg <= redirect_pc;
        rd_ptr_reg   <= '0;
        wr_ptr_reg   <= '0;
        count_reg    <= '0;
      end else begin
        count_reg <= count_next;
        if (push) begin
          fetch_pc_reg <= fetch_pc_reg + ADDR_BIT'(1);
          wr_ptr_reg   <= wr_ptr_reg + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
        end
      end
    end
  end

  // Storage needs no reset: entries are only observable while counted.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (push && (wr_ptr_reg == PTR_W'(gi))) begin
        pc_mem_reg[gi]   <= fetch_pc_reg;
        inst_mem_reg[gi] <= imem_inst;
      end
    end
  end

  assign imem_addr     = fetch_pc_reg;
  assign count         = count_reg;
  assign deq.out_valid = (count_reg != '0);
  assign deq.out_pc    = pc_mem_reg[rd_ptr_reg];
  assign deq.out_pc_4  = pc_mem_reg[rd_ptr_reg] + ADDR_BIT'(1);
  assign deq.out_inst  = inst_mem_reg[rd_ptr_reg];

`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] perf_fetched_reg;
  logic [31:0] perf_flushed_reg;
  logic [32:0] flushed_sum;

  assign flushed_sum = {1'b0, perf_flushed_reg} + 33'(count_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_reg <= '0;
      perf_flushed_reg <= '0;
    end else if (en) begin
      if (push && (perf_fetched_reg != 32'hFFFF_FFFF)) begin
        perf_fetched_reg <= perf_fetched_reg + 32'd1;
      end
      if (redirect) begin
        perf_flushed_reg <= flushed_sum[32] ? 32'hFFFF_FFFF : flushed_sum[31:0];
      end
    end
  end

  assign perf_fetched = perf_fetched_reg;
  assign perf_flushed = perf_flushed_reg;
`endif

endmodule

// File: tb/tb_syn_fetch_queue.sv
// Directed bench for syn_fetch_queue: a 10-bit-address main instance and a 4-bit wrap instance.
`timescale 1ns/1ps
module tb_syn_fetch_queue;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        halt;
  logic        redirect;
  logic [9:0]  redirect_pc;
  logic [9:0]  imem_addr;
  logic [31:0] imem_inst;
  logic [2:0]  count;

  logic        en_s;
  logic        halt_s;
  logic        redirect_s;
  logic [3:0]  redirect_pc_s;
  logic [3:0]  imem_addr_s;
  logic [31:0] imem_inst_s;
  logic [2:0]  count_s;

  int tests_run;
  int tests_failed;

`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] perf_fetched, perf_flushed, perf_fetched_s, perf_flushed_s;
`endif

  syn_fetch_queue_if #(.ADDR_BIT(10)) q_if ();
  syn_fetch_queue_if #(.ADDR_BIT(4))  s_if ();

  function automatic logic [31:0] inst_of(input logic [9:0] a);
    return {16'hC0DE, 6'd0, a};
  endfunction

  function automatic logic [31:0] inst_of_s(input logic [3:0] a);
    return {28'hB00000A, a};
  endfunction

  assign imem_inst   = inst_of(imem_addr);
  assign imem_inst_s = inst_of_s(imem_addr_s);

  syn_fetch_queue #(.ADDR_BIT(10), .DEPTH(4), .RESET_PC(0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .halt(halt), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_inst(imem_inst),
    .deq(q_if.master), .count(count)
`ifdef FETCH_QUEUE_PERF_EN
    , .perf_fetched(perf_fetched), .perf_flushed(perf_flushed)
`endif
  );

  syn_fetch_queue #(.ADDR_BIT(4), .DEPTH(4), .RESET_PC(15)) dut_s (
    .clk(clk), .rst_n(rst_n), .en(en_s), .halt(halt_s), .redirect(redirect_s),
    .redirect_pc(redirect_pc_s), .imem_addr(imem_addr_s), .imem_inst(imem_inst_s),
    .deq(s_if.master), .count(count_s)
`ifdef FETCH_QUEUE_PERF_EN
    , .perf_fetched(perf_fetched_s), .perf_flushed(perf_flushed_s)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Checks the main instance's head entry against the bench memory model.
  task automatic check_head(input string tag, input logic [9:0] pc);
    check({tag, ".pc"},   64'(q_if.out_pc),   64'(pc));
    check({tag, ".pc_4"}, 64'(q_if.out_pc_4), 64'(pc + 10'd1));
    check({tag, ".inst"}, 64'(q_if.out_inst), 64'(inst_of(pc)));
  endtask

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    rst_n         = 1'b0;
    en            = 1'b1;
    halt          = 1'b0;
    redirect      = 1'b0;
    redirect_pc   = '0;
    q_if.out_ready = 1'b0;
    en_s          = 1'b1;
    halt_s        = 1'b0;
    redirect_s    = 1'b0;
    redirect_pc_s = '0;
    s_if.out_ready = 1'b1;

    step();
    step();
    check("rst.count", 64'(count), 64'd0);
    check("rst.valid", 64'(q_if.out_valid), 64'd0);
    check("rst.imem_addr", 64'(imem_addr), 64'd0);
    check("rst_s.imem_addr", 64'(imem_addr_s), 64'd15);

    // Fill with decode stalled: count 1,2,3,4 then holds.
    rst_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      check($sformatf("fill%0d.count", i), 64'(count), 64'(i > 4 ? 4 : i));
      check($sformatf("fill%0d.valid", i), 64'(q_if.out_valid), 64'd1);
      check($sformatf("fill%0d.imem_addr", i), 64'(imem_addr), 64'(i > 4 ? 4 : i));
      if (i == 1) begin
        check("wrap_s0.pc", 64'(s_if.out_pc), 64'd15);
        check("wrap_s0.pc_4", 64'(s_if.out_pc_4), 64'd0);
        check("wrap_s0.inst", 64'(s_if.out_inst), 64'(inst_of_s(4'd15)));
        check("wrap_s0.imem_addr", 64'(imem_addr_s), 64'd0);
      end else if (i == 2) begin
        check("wrap_s1.pc", 64'(s_if.out_pc), 64'd0);
        check("wrap_s1.pc_4", 64'(s_if.out_pc_4), 64'd1);
        check("wrap_s1.count", 64'(count_s), 64'd1);
      end
    end
    check_head("fill", 10'd0);

    // Full with decode ready: push+pop each cycle, count stays 4.
    q_if.out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      check($sformatf("full%0d.count", i), 64'(count), 64'd4);
      check_head($sformatf("full%0d", i), 10'(i));
      check($sformatf("full%0d.imem_addr", i), 64'(imem_addr), 64'(4 + i));
    end

    // en=0 freezes everything, with redirect/halt/ready all active.
    en          = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 10'h3F0;
    halt        = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("frz.count", 64'(count), 64'd4);
    check("frz.imem_addr", 64'(imem_addr), 64'd7);
    check_head("frz", 10'd3);
    en       = 1'b1;
    redirect = 1'b0;

    // One halted cycle: pop only, count 3.
    step();
    check("halt1.count", 64'(count), 64'd3);
    check("halt1.imem_addr", 64'(imem_addr), 64'd7);
    check_head("halt1", 10'd4);
    halt = 1'b0;

    // Redirect flushes three entries.
    redirect    = 1'b1;
    redirect_pc = 10'h040;
    step();
    check("redir.count", 64'(count), 64'd0);
    check("redir.valid", 64'(q_if.out_valid), 64'd0);
    check("redir.imem_addr", 64'(imem_addr), 64'h40);
`ifdef FETCH_QUEUE_PERF_EN
    check("perf.flushed", 64'(perf_flushed), 64'd3);
    check("perf.fetched", 64'(perf_fetched), 64'd7);
`endif
    redirect = 1'b0;

    // Steady streaming from empty: count stays 1, one entry per cycle.
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("strm%0d.count", i), 64'(count), 64'd1);
      check_head($sformatf("strm%0d", i), 10'(10'h040 + i));
    end

    // halt drains the queue and freezes fetch.
    halt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("drain%0d.count", i), 64'(count), 64'd0);
      check($sformatf("drain%0d.imem_addr", i), 64'(imem_addr), 64'h44);
    end

    // Redirect under halt loads fetch_pc but fetches nothing.
    redirect    = 1'b1;
    redirect_pc = 10'h100;
    step();
    redirect = 1'b0;
    step();
    check("hredir.count", 64'(count), 64'd0);
    check("hredir.imem_addr", 64'(imem_addr), 64'h100);
    halt = 1'b0;
    q_if.out_ready = 1'b0;
    step();
    check("hredir.valid", 64'(q_if.out_valid), 64'd1);
    check_head("hredir", 10'h100);
    step();
    check("pre_rst.count", 64'(count), 64'd2);

    // Asynchronous reset mid-cycle clears state without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.count", 64'(count), 64'd0);
    check("arst.valid", 64'(q_if.out_valid), 64'd0);
    check("arst.imem_addr", 64'(imem_addr), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
